// File: rtl/cpu_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : cpu_pkg
//  Purpose  : Shared pipeline types and widths.
//             - XLEN / REG_ADDR_W : datapath and register-index widths
//             - mem_state_e       : memory-stage access FSM states
//  Revision : 1.0  initial release
// ============================================================================
package cpu_pkg;

    localparam int XLEN       = 32;
    localparam int REG_ADDR_W = 5;

    // IDLE     : stage accepts a new instruction every cycle
    // WAIT_RSP : a load has been accepted by memory, data not yet returned
    typedef enum logic [0:0] {
        IDLE     = 1'b0,
        WAIT_RSP = 1'b1
    } mem_state_e;

endpackage : cpu_pkg
`default_nettype wire

// File: rtl/mem_stage.sv
`default_nettype none
// ============================================================================
//  Module   : mem_stage
//  Purpose  : Memory-access stage of the 5-stage pipeline. Issues loads and
//             stores on a valid/ready request channel, waits for load data on
//             a valid-only response channel, stalls the front of the pipeline
//             while an access is outstanding, and registers MEM/WB state.
//  Ports    :
//    clk, reset                 clock, synchronous active-high reset
//    mem_*                      EX/MEM register contents (held while stalled)
//    stall                      hold EX/MEM and all earlier stages
//    dmem_req_*                 data-memory request channel (unregistered)
//    dmem_rsp_valid/_rdata      data-memory load response
//    wb_reg_write, wb_rd,
//    wb_data                    registered MEM/WB state
//    mem_err                    registered 1-cycle error pulse (misaligned,
//                               read+write together, or load timeout)
//  Revision : 1.0  initial release
// ============================================================================
module mem_stage
    import cpu_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [XLEN-1:0]       mem_alu_result,
    input  logic [XLEN-1:0]       mem_rs2_val,
    input  logic [REG_ADDR_W-1:0] mem_rd,
    input  logic                  mem_mem_read,
    input  logic                  mem_mem_write,
    input  logic                  mem_reg_write,
    input  logic                  mem_mem_to_reg,
    input  logic                  mem_jal,
    input  logic [XLEN-1:0]       mem_pc_plus4,
    output logic                  stall,
    output logic                  dmem_req_valid,
    input  logic                  dmem_req_ready,
    output logic [XLEN-1:0]       dmem_req_addr,
    output logic                  dmem_req_we,
    output logic [XLEN-1:0]       dmem_req_wdata,
    input  logic                  dmem_rsp_valid,
    input  logic [XLEN-1:0]       dmem_rsp_rdata,
    output logic                  wb_reg_write,
    output logic [REG_ADDR_W-1:0] wb_rd,
    output logic [XLEN-1:0]       wb_data,
    output logic                  mem_err
);

    // A single-cycle timeout would need a zero-width counter; keep >= 1 bit.
    localparam int              C_CNT_W    = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [C_CNT_W-1:0] C_CNT_LAST = C_CNT_W'(TIMEOUT_CYCLES - 1);

    mem_state_e            r_state;
    logic [C_CNT_W-1:0]    r_wait_cnt;

    logic                  w_access;
    logic                  w_bad_access;
    logic                  w_timeout;
    logic                  w_rf_we;

    assign w_access     = mem_mem_read | mem_mem_write;
    assign w_bad_access = w_access & ((mem_alu_result[1:0] != 2'b00) |
                                      (mem_mem_read & mem_mem_write));
    assign w_timeout    = (r_state == WAIT_RSP) && (r_wait_cnt == C_CNT_LAST);
    // x0 is hard-wired, so a write to it is never forwarded to the register file.
    assign w_rf_we      = mem_reg_write && (mem_rd != '0);

    // Request fields pass straight through; upstream holds them while stalled.
    assign dmem_req_addr  = mem_alu_result;
    assign dmem_req_wdata = mem_rs2_val;

    always_comb begin
        stall          = 1'b0;
        dmem_req_valid = 1'b0;
        dmem_req_we    = 1'b0;
        if (!reset) begin
            case (r_state)
                IDLE: begin
                    if (w_access && !w_bad_access) begin
                        dmem_req_valid = 1'b1;
                        dmem_req_we    = mem_mem_write;
                        // Stores are posted: free to advance once accepted.
                        // Loads always hold at least through acceptance.
                        stall          = mem_mem_write ? !dmem_req_ready : 1'b1;
                    end
                end
                WAIT_RSP: begin
                    // Release in the response (or final timeout) cycle so
                    // EX/MEM advances on the same edge WB captures the result.
                    stall = !dmem_rsp_valid && !w_timeout;
                end
                default: begin
                    stall = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= IDLE;
            r_wait_cnt   <= '0;
            wb_reg_write <= 1'b0;
            wb_rd        <= '0;
            wb_data      <= '0;
            mem_err      <= 1'b0;
        end else begin
            // Bubble by default; only completing instructions overwrite it.
            wb_reg_write <= 1'b0;
            wb_rd        <= '0;
            wb_data      <= '0;
            mem_err      <= 1'b0;

            case (r_state)
                IDLE: begin
                    if (!w_access) begin
                        wb_reg_write <= w_rf_we;
                        wb_rd        <= mem_rd;
                        wb_data      <= mem_jal ? mem_pc_plus4 : mem_alu_result;
                    end else if (w_bad_access) begin
                        mem_err <= 1'b1;
                    end else if (!mem_mem_write && dmem_req_ready) begin
                        r_state    <= WAIT_RSP;
                        r_wait_cnt <= '0;
                    end
                end
                WAIT_RSP: begin
                    if (dmem_rsp_valid) begin
                        wb_reg_write <= w_rf_we;
                        wb_rd        <= mem_rd;
                        wb_data      <= mem_mem_to_reg ? dmem_rsp_rdata : mem_alu_result;
                        r_state      <= IDLE;
                    end else if (w_timeout) begin
                        mem_err <= 1'b1;
                        r_state <= IDLE;
                    end else if (r_wait_cnt != C_CNT_LAST) begin
                        r_wait_cnt <= r_wait_cnt + 1'b1;
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

endmodule : mem_stage
`default_nettype wire

// File: tb/tb_mem_stage.sv
`default_nettype none
// ============================================================================
//  Module   : tb_mem_stage
//  Purpose  : Self-checking bench for mem_stage. Each instruction is described
//             by its kind and memory behaviour (cycles until ready, cycles
//             until response); the expected stall length, request activity
//             and final MEM/WB values are derived per instruction.
//  Revision : 1.0  initial release
// ============================================================================
module tb_mem_stage;

    localparam int TMO = 16;

    localparam int K_ALU   = 0;
    localparam int K_LOAD  = 1;
    localparam int K_STORE = 2;
    localparam int K_RW    = 3;

    logic        clk;
    logic        reset;
    logic [31:0] mem_alu_result;
    logic [31:0] mem_rs2_val;
    logic [4:0]  mem_rd;
    logic        mem_mem_read;
    logic        mem_mem_write;
    logic        mem_reg_write;
    logic        mem_mem_to_reg;
    logic        mem_jal;
    logic [31:0] mem_pc_plus4;
    logic        stall;
    logic        dmem_req_valid;
    logic        dmem_req_ready;
    logic [31:0] dmem_req_addr;
    logic        dmem_req_we;
    logic [31:0] dmem_req_wdata;
    logic        dmem_rsp_valid;
    logic [31:0] dmem_rsp_rdata;
    logic        wb_reg_write;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic        mem_err;

    int n_checks = 0;
    int n_pass   = 0;

    mem_stage #(.TIMEOUT_CYCLES(TMO)) dut (
        .clk            (clk),
        .reset          (reset),
        .mem_alu_result (mem_alu_result),
        .mem_rs2_val    (mem_rs2_val),
        .mem_rd         (mem_rd),
        .mem_mem_read   (mem_mem_read),
        .mem_mem_write  (mem_mem_write),
        .mem_reg_write  (mem_reg_write),
        .mem_mem_to_reg (mem_mem_to_reg),
        .mem_jal        (mem_jal),
        .mem_pc_plus4   (mem_pc_plus4),
        .stall          (stall),
        .dmem_req_valid (dmem_req_valid),
        .dmem_req_ready (dmem_req_ready),
        .dmem_req_addr  (dmem_req_addr),
        .dmem_req_we    (dmem_req_we),
        .dmem_req_wdata (dmem_req_wdata),
        .dmem_rsp_valid (dmem_rsp_valid),
        .dmem_rsp_rdata (dmem_rsp_rdata),
        .wb_reg_write   (wb_reg_write),
        .wb_rd          (wb_rd),
        .wb_data        (wb_data),
        .mem_err        (mem_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", tag, got, exp, $time);
    endtask

    task automatic chk_bubble(input string tag);
        chk({tag, ".wb_reg_write"}, {31'd0, wb_reg_write}, 32'd0);
        chk({tag, ".wb_rd"},        {27'd0, wb_rd},        32'd0);
        chk({tag, ".wb_data"},      wb_data,               32'd0);
        chk({tag, ".mem_err"},      {31'd0, mem_err},      32'd0);
    endtask

    // Runs one instruction from first presentation until it leaves the stage.
    // Called and returns at posedge+1. rsp_delay = cycles after acceptance at
    // which load data arrives; beyond TMO means it never arrives in time.
    task automatic run_instr(input int kind, input logic [31:0] addr,
                             input logic [31:0] rs2, input logic [4:0] rd,
                             input logic rw, input logic m2r, input logic jal,
                             input logic [31:0] pc4, input logic [31:0] rdata,
                             input int ready_wait, input int rsp_delay);
        bit is_load, is_store, access, err, responded;
        int n;
        logic exp_rv;
        logic [31:0] exp_data;
        logic exp_we;
        is_load   = (kind == K_LOAD) || (kind == K_RW);
        is_store  = (kind == K_STORE) || (kind == K_RW);
        access    = is_load || is_store;
        err       = access && ((addr[1:0] != 2'b00) || (kind == K_RW));
        responded = (rsp_delay <= TMO);
        if (!access || err)  n = 1;
        else if (is_store)   n = ready_wait + 1;
        else                 n = ready_wait + (responded ? rsp_delay : TMO) + 1;

        mem_alu_result = addr;
        mem_rs2_val    = rs2;
        mem_rd         = rd;
        mem_mem_read   = is_load;
        mem_mem_write  = is_store;
        mem_reg_write  = rw;
        mem_mem_to_reg = m2r;
        mem_jal        = jal;
        mem_pc_plus4   = pc4;

        for (int i = 0; i < n; i++) begin
            if (access && !err && i <= ready_wait)
                dmem_req_ready = (i == ready_wait);
            else
                dmem_req_ready = 1'($urandom_range(0, 1));
            if (is_load && access && !err && i > ready_wait) begin
                dmem_rsp_valid = responded && ((i - ready_wait) == rsp_delay);
                dmem_rsp_rdata = dmem_rsp_valid ? rdata : $urandom;
            end else begin
                // Response noise outside a load wait must be ignored.
                dmem_rsp_valid = 1'($urandom_range(0, 1));
                dmem_rsp_rdata = $urandom;
            end
            #1;
            exp_rv = access && !err && (i <= ready_wait);
            chk("stall",          {31'd0, stall},          {31'd0, (i < n - 1)});
            chk("dmem_req_valid", {31'd0, dmem_req_valid}, {31'd0, exp_rv});
            if (exp_rv) begin
                chk("dmem_req_we",    {31'd0, dmem_req_we}, {31'd0, is_store});
                chk("dmem_req_addr",  dmem_req_addr,        addr);
                chk("dmem_req_wdata", dmem_req_wdata,       rs2);
            end
            @(posedge clk);
            #1;
            if (i < n - 1) begin
                chk_bubble("stalled");
            end else if (err || is_store || (is_load && !responded)) begin
                chk("final.wb_reg_write", {31'd0, wb_reg_write}, 32'd0);
                chk("final.wb_rd",        {27'd0, wb_rd},        32'd0);
                chk("final.wb_data",      wb_data,               32'd0);
                chk("final.mem_err",      {31'd0, mem_err},      {31'd0, (err || is_load)});
            end else begin
                exp_we = rw && (rd != 5'd0);
                if (is_load) exp_data = m2r ? rdata : addr;
                else         exp_data = jal ? pc4 : addr;
                chk("final.wb_reg_write", {31'd0, wb_reg_write}, {31'd0, exp_we});
                chk("final.wb_rd",        {27'd0, wb_rd},        {27'd0, rd});
                chk("final.wb_data",      wb_data,               exp_data);
                chk("final.mem_err",      {31'd0, mem_err},      32'd0);
            end
        end
    endtask

    initial begin
        // Reset with a valid load presented: request side must stay quiet.
        reset          = 1'b1;
        mem_alu_result = 32'h100;
        mem_rs2_val    = 32'h55;
        mem_rd         = 5'd3;
        mem_mem_read   = 1'b1;
        mem_mem_write  = 1'b0;
        mem_reg_write  = 1'b1;
        mem_mem_to_reg = 1'b1;
        mem_jal        = 1'b0;
        mem_pc_plus4   = 32'h4;
        dmem_req_ready = 1'b1;
        dmem_rsp_valid = 1'b1;
        dmem_rsp_rdata = 32'hCAFE_F00D;
        #1;
        chk("rst.stall",     {31'd0, stall},          32'd0);
        chk("rst.req_valid", {31'd0, dmem_req_valid}, 32'd0);
        chk("rst.req_we",    {31'd0, dmem_req_we},    32'd0);
        @(posedge clk);
        #1;
        chk_bubble("rst");
        @(posedge clk);
        #1;
        chk_bubble("rst2");
        reset = 1'b0;

        // Directed cases
        run_instr(K_ALU,   32'h0000_1234, 32'h0, 5'd5, 1'b1, 1'b0, 1'b0, 32'h0,         32'h0,         0, 1);
        run_instr(K_ALU,   32'h0000_0040, 32'h0, 5'd9, 1'b1, 1'b0, 1'b1, 32'h0000_2004, 32'h0,         0, 1);
        run_instr(K_ALU,   32'h0000_0077, 32'h0, 5'd0, 1'b1, 1'b0, 1'b0, 32'h0,         32'h0,         0, 1);
        run_instr(K_LOAD,  32'h0000_0100, 32'h0, 5'd7, 1'b1, 1'b1, 1'b0, 32'h0,         32'hDEAD_BEEF, 0, 3);
        run_instr(K_STORE, 32'h0000_0200, 32'hA5A5_0001, 5'd0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0,         2, 1);
        run_instr(K_LOAD,  32'h0000_0102, 32'h0, 5'd8, 1'b1, 1'b1, 1'b0, 32'h0,         32'h0,         0, 1);
        run_instr(K_RW,    32'h0000_0300, 32'h1, 5'd8, 1'b1, 1'b1, 1'b0, 32'h0,         32'h0,         0, 1);
        run_instr(K_LOAD,  32'h0000_0400, 32'h0, 5'd6, 1'b1, 1'b1, 1'b0, 32'h0,         32'h1111_2222, 0, 99);
        run_instr(K_ALU,   32'h0000_0010, 32'h0, 5'd4, 1'b1, 1'b0, 1'b0, 32'h0,         32'h0,         0, 1);
        run_instr(K_LOAD,  32'h0000_0404, 32'h0, 5'd6, 1'b1, 1'b1, 1'b0, 32'h0,         32'h3333_4444, 1, TMO);
        run_instr(K_LOAD,  32'h0000_0408, 32'h0, 5'd6, 1'b1, 1'b0, 1'b0, 32'h0,         32'h5555_6666, 0, 1);

        // Reset while a load is waiting: abandoned, no writeback, no error.
        mem_alu_result = 32'h0000_0500;
        mem_rd         = 5'd12;
        mem_mem_read   = 1'b1;
        mem_mem_write  = 1'b0;
        mem_reg_write  = 1'b1;
        mem_mem_to_reg = 1'b1;
        mem_jal        = 1'b0;
        dmem_req_ready = 1'b1;
        dmem_rsp_valid = 1'b0;
        @(posedge clk);
        #1;
        dmem_req_ready = 1'b0;
        @(posedge clk);
        #1;
        reset          = 1'b1;
        dmem_rsp_valid = 1'b1;
        dmem_rsp_rdata = 32'hBAD0_BAD0;
        #1;
        chk("rstw.stall",     {31'd0, stall},          32'd0);
        chk("rstw.req_valid", {31'd0, dmem_req_valid}, 32'd0);
        @(posedge clk);
        #1;
        chk_bubble("rstw");
        reset = 1'b0;
        run_instr(K_ALU,  32'h0000_0ABC, 32'h0, 5'd13, 1'b1, 1'b0, 1'b0, 32'h0, 32'h0,         0, 1);
        run_instr(K_LOAD, 32'h0000_0600, 32'h0, 5'd14, 1'b1, 1'b1, 1'b0, 32'h0, 32'h7777_8888, 0, TMO);

        // Randomized instruction stream
        for (int t = 0; t < 120; t++) begin
            int          kind;
            logic [31:0] addr;
            kind = $urandom_range(0, 9);
            kind = (kind < 4) ? K_ALU : (kind < 7) ? K_LOAD : (kind < 9) ? K_STORE : K_RW;
            addr = $urandom;
            if ($urandom_range(0, 4) != 0) addr[1:0] = 2'b00;
            run_instr(kind, addr, $urandom, 5'($urandom_range(0, 31)),
                      1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                      1'($urandom_range(0, 1)), $urandom, $urandom,
                      $urandom_range(0, 3), $urandom_range(1, TMO + 3));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule : tb_mem_stage
`default_nettype wire
